// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and a
// bit-shifting helper. The transmitter uses this package as well.
package uart_pkg;

  // 100 MHz system clock at 9600 baud.
  localparam int UART_CLKS_PER_BIT = 10416;

  // Receiver FSM state encoding.
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE      = 3'd0;
  localparam uart_state_t ST_START     = 3'd1;
  localparam uart_state_t ST_DATA      = 3'd2;
  localparam uart_state_t ST_STOP      = 3'd3;
  localparam uart_state_t ST_WAIT_HIGH = 3'd4;

  // Serial data is LSB first: each new bit enters at the MSB and the
  // register shifts right, so after eight bits bit 0 sits at position 0.
  function automatic logic [7:0] shift_in_lsb_first(input logic [7:0] sr,
                                                    input logic       b);
    return {b, sr[7:1]};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// high so the idle line never looks like a start bit coming out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out
);

  logic meta;

  // Shift the raw line through two flops; reset to the idle (high) level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      out  <= 1'b1;
    end else begin
      meta <= in;
      out  <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver. A falling edge on the synchronized line starts a frame;
// the start bit is re-checked at mid-bit, then data and stop bits are sampled
// one full bit period apart so every sample lands near the bit centre.
//
// Output handshake: data_valid and framing_error are single-cycle pulses with
// no back-pressure; data is stable from the data_valid pulse until the next
// good frame, and the consumer must capture it on the pulse if it needs it.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  // Compare values for the half-bit (start check) and full-bit intervals.
  localparam logic [15:0] HALF_BIT_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_BIT_LAST = 16'(CLKS_PER_BIT - 1);

  // FSM state is a named signal so checkers can bind to it directly.
  uart_state_t state;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        rx;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (RxD),
    .out   (rx)
  );

  // Busy covers every state that is part of a frame or its recovery.
  assign busy = (state != ST_IDLE);

  // Receive FSM with bit timer, bit index, shift register and output pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      timer         <= 16'd0;
      bit_idx       <= 3'd0;
      shift_reg     <= 8'h00;
      data          <= 8'h00;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      // Pulses are one cycle wide unless set again below.
      data_valid    <= 1'b0;
      framing_error <= 1'b0;

      case (state)
        ST_IDLE: begin
          timer   <= 16'd0;
          bit_idx <= 3'd0;
          if (!rx) begin
            state <= ST_START;
          end
        end

        ST_START: begin
          if (timer == HALF_BIT_LAST) begin
            timer <= 16'd0;
            // A line that is high again at mid-bit was only a glitch.
            if (!rx) begin
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end

        ST_DATA: begin
          if (timer == FULL_BIT_LAST) begin
            timer     <= 16'd0;
            shift_reg <= shift_in_lsb_first(shift_reg, rx);
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end

        ST_STOP: begin
          if (timer == FULL_BIT_LAST) begin
            timer <= 16'd0;
            if (rx) begin
              data       <= shift_reg;
              data_valid <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              // Bad stop bit: report once, then wait out a held-low line.
              framing_error <= 1'b1;
              state         <= ST_WAIT_HIGH;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end

        ST_WAIT_HIGH: begin
          timer <= 16'd0;
          if (rx) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          timer <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit. Expected bytes are
// queued as frames are driven and popped when data_valid pulses.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       RxD;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;
  int dv_cnt     = 0;
  int fe_cnt     = 0;
  int fall_cyc   = 0;
  int last_dv_cyc = 0;
  int prev_dv_cyc = 0;

  logic [7:0] exp_q[$];

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RxD           (RxD),
    .data          (data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Scoreboard: pop expected bytes on data_valid, track pulse counts/timing.
  always @(negedge clk) begin
    if (rst_n && (data_valid || framing_error)) begin
      chk("pulse_exclusive", {31'd0, data_valid & framing_error}, 32'd0);
    end
    if (rst_n && framing_error) fe_cnt++;
    if (rst_n && data_valid) begin
      dv_cnt++;
      prev_dv_cyc = last_dv_cyc;
      last_dv_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_data_valid", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("data", {24'd0, data}, {24'd0, e});
      end
    end
  end

  // Driver: hold the line at one level for a number of clocks.
  task automatic drive(input logic v, input int n);
    RxD = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Driver: one 8N1 frame with a chosen stop-bit level.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    fall_cyc = cyc;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop_bit, CPB);
  endtask

  initial begin
    int dv0, fe0, lat;
    rst_n = 1'b0;
    RxD   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {24'd0, data}, 32'h00);
    chk("rst_dv", {31'd0, data_valid}, 32'd0);
    chk("rst_fe", {31'd0, framing_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 5);

    // Single good frame and its latency from the falling edge.
    dv0 = dv_cnt; fe0 = fe_cnt;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    drive(1'b1, 4);
    chk("dv_count_55", dv_cnt - dv0, 32'd1);
    chk("fe_count_55", fe_cnt - fe0, 32'd0);
    lat = last_dv_cyc - fall_cyc;
    chk("latency", {31'd0, (lat >= 2 + CPB/2 + 9*CPB - 1) && (lat <= 2 + CPB/2 + 9*CPB + 1)}, 32'd1);
    chk("busy_after_55", {31'd0, busy}, 32'd0);

    // Back-to-back frames with no idle gap.
    dv0 = dv_cnt;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    drive(1'b1, 4);
    chk("dv_count_b2b", dv_cnt - dv0, 32'd2);
    chk("b2b_spacing", last_dv_cyc - prev_dv_cyc, 32'd160);
    chk("data_hold_0f", {24'd0, data}, 32'h0F);

    // Short low glitch: rejected at the start-bit mid-sample.
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive(1'b0, 5);
    drive(1'b1, 2);
    chk("glitch_busy_high", {31'd0, busy}, 32'd1);
    drive(1'b1, 7);
    chk("glitch_busy_low", {31'd0, busy}, 32'd0);
    drive(1'b1, 20);
    chk("glitch_no_dv", dv_cnt - dv0, 32'd0);
    chk("glitch_no_fe", fe_cnt - fe0, 32'd0);
    chk("glitch_data", {24'd0, data}, 32'h0F);

    // Bad stop bit: one framing error, data retained.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_byte(8'hC6, 1'b0);
    drive(1'b1, 20);
    chk("badstop_fe", fe_cnt - fe0, 32'd1);
    chk("badstop_no_dv", dv_cnt - dv0, 32'd0);
    chk("badstop_data", {24'd0, data}, 32'h0F);
    chk("badstop_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    drive(1'b1, 4);
    chk("after_bad_data", {24'd0, data}, 32'h81);

    // Break: line held low for a long time.
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive(1'b0, 400);
    chk("break_fe", fe_cnt - fe0, 32'd1);
    chk("break_state", {29'd0, dut.state}, {29'd0, ST_WAIT_HIGH});
    chk("break_busy", {31'd0, busy}, 32'd1);
    drive(1'b1, 5);
    chk("break_release_busy", {31'd0, busy}, 32'd0);
    chk("break_no_dv", dv_cnt - dv0, 32'd0);
    chk("break_data", {24'd0, data}, 32'h81);

    // Reset pulse during bit 4 of 0x7E; the rest of the frame is dropped.
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(logic'((8'h7E >> i) & 8'h01), CPB);
    drive(1'b1, CPB/2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_data", {24'd0, data}, 32'h00);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_dv", {31'd0, data_valid}, 32'd0);
    chk("midrst_fe", {31'd0, framing_error}, 32'd0);
    drive(1'b1, 200);
    chk("midrst_no_dv", dv_cnt - dv0, 32'd0);
    chk("midrst_no_fe", fe_cnt - fe0, 32'd0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    drive(1'b1, 4);
    chk("post_rst_data", {24'd0, data}, 32'h3C);
    chk("post_rst_dv", dv_cnt - dv0, 32'd1);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
